timer0_wdt_unit: RTL
====================

TIMER0_WDT_UNIT -- requirements
Module: timer0_wdt_unit

Interface
REQ-001 SHALL have parameter TMR_W, default 8, timer register width.
REQ-002 SHALL have parameter PS_SEL_W, default 3, prescaler-select width; the prescaler counter width is 2^PS_SEL_W.
REQ-003 SHALL have parameter WDT_W, default 8, watchdog base counter width.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- t0cs  in  1  0 = internal tick each clk; 1 = external pin.
- t0se  in  1  0 = external rising edge; 1 = external falling edge.
- psa  in  1  0 = prescaler assigned to timer; 1 = assigned to watchdog.
- ps  in  PS_SEL_W  prescaler ratio select.
- t0cki  in  1  asynchronous external clock pin.
- tmr_wr  in  1  load timer from tmr_wdata.
- tmr_wdata  in  TMR_W  timer load value.
- ovf_clr  in  1  clear the overflow flag.
- wdt_en  in  1  watchdog enable.
- clrwdt  in  1  clear the watchdog.
- sleep  in  1  enter sleep; clears the watchdog.
- tmr_q  out  TMR_W  timer value.
- tmr_ovf  out  1  sticky overflow flag.
- wdt_timeout  out  1  one-cycle watchdog expiry pulse.

Function
REQ-005 SHALL synchronise t0cki through two flip-flops plus one edge register; an external tick SHALL assert exactly once per selected edge, on the 3rd rising clk edge after the pin transition.
REQ-006 SHALL define a tick as every clk cycle when t0cs=0, and as the synchronised selected edge when t0cs=1.
REQ-007 With psa=0, each tick SHALL increment the prescaler counter; tmr_q SHALL increment on a tick when (ps_cnt & M)==M, where M = 2^(ps+1)-1, giving a ratio of 2^(ps+1).
REQ-008 With psa=1, each tick SHALL increment tmr_q directly (ratio 1).
REQ-009 tmr_q SHALL wrap from all-ones to 0 modulo 2^TMR_W; the wrap SHALL set tmr_ovf on the same edge.
REQ-010 tmr_ovf SHALL clear on ovf_clr; if set and ovf_clr occur together, set SHALL win.
REQ-011 tmr_wr SHALL load tmr_wdata on the next edge, clear the prescaler when psa=0, and drop any tick in that cycle.
REQ-012 After a load, increments SHALL be inhibited for the 2 following cycles; ticks in those cycles are lost.
REQ-013 A load of all-ones SHALL NOT set tmr_ovf; only an increment wrap sets it.
REQ-014 When wdt_en=1, the watchdog base counter SHALL increment every clk; its wrap to 0 SHALL produce one watchdog tick.
REQ-015 With psa=1, watchdog ticks SHALL drive the prescaler; expiry SHALL occur on a tick when (ps_cnt & N)==N, where N = 2^ps-1 (ratio 2^ps; ps=0 means every tick).
REQ-016 With psa=0, each watchdog tick SHALL be an expiry.
REQ-017 On expiry, wdt_timeout SHALL be 1 for exactly one cycle, and the base counter and watchdog-assigned prescaler SHALL restart from 0.
REQ-018 clrwdt or sleep SHALL clear the base counter and, when psa=1, the prescaler; this SHALL take priority over a same-cycle expiry (no pulse).
REQ-019 A change of psa or ps SHALL clear the prescaler on the next edge.
REQ-020 With wdt_en=0, the watchdog counter SHALL hold, and the prescaler SHALL NOT count watchdog ticks.
REQ-021 The timer SHALL keep counting external ticks during sleep; internal ticks SHALL be gated while sleep=1.

Reset
REQ-022 rst SHALL immediately force tmr_q=0, ps_cnt=0, watchdog counter=0, tmr_ovf=0, wdt_timeout=0, and all synchroniser and edge registers to 0.
REQ-023 rst asserted mid-operation SHALL discard pending ticks, load inhibits and expiries; counting SHALL resume on the first edge after release.

Verification
REQ-024 t0cs=0, psa=1, release rst -> tmr_q=0x10 after 16 clks; tmr_ovf=1 at clk 256 with tmr_q=0x00; ovf_clr -> tmr_ovf=0.
REQ-025 psa=0, ps=1 -> tmr_q increments every 4 clks; tmr_q=0x05 after 20 clks.
REQ-026 tmr_wr with 0xFE -> tmr_q=0xFE held 3 cycles, then 0xFF, then 0x00 with tmr_ovf=1.
REQ-027 t0cs=1, t0se=0, pulse t0cki high -> tmr_q +1 on the 3rd edge after the rise; t0se=1 -> increment after the fall only.
REQ-028 WDT_W=4, psa=1, ps=2, wdt_en=1 -> wdt_timeout pulse at clk 64; clrwdt at clk 40 -> next pulse at clk 104.
REQ-029 ovf_clr in the wrap cycle -> tmr_ovf=1; rst at clk 100 -> all outputs 0 immediately, counting restarts from 0.

Source files
------------

// File: rtl/timer0_wdt_unit.sv
// Timer0 with a prescaler shared between the timer and the watchdog.
// External clock pin is synchronised and edge-detected before use.
module timer0_wdt_unit #(
  parameter int TMR_W    = 8,
  parameter int PS_SEL_W = 3,
  parameter int WDT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                t0cs,
  input  logic                t0se,
  input  logic                psa,
  input  logic [PS_SEL_W-1:0] ps,
  input  logic                t0cki,
  input  logic                tmr_wr,
  input  logic [TMR_W-1:0]    tmr_wdata,
  input  logic                ovf_clr,
  input  logic                wdt_en,
  input  logic                clrwdt,
  input  logic                sleep,
  output logic [TMR_W-1:0]    tmr_q,
  output logic                tmr_ovf,
  output logic                wdt_timeout
);

  localparam int PS_W = 2 ** PS_SEL_W;
  localparam logic [PS_W:0] SPAN_ONE = {{PS_W{1'b0}}, 1'b1};

  logic                sync1_reg, sync2_reg, edge_reg;
  logic [TMR_W-1:0]    tmr_reg, tmr_next;
  logic                tmr_ovf_reg, ovf_next;
  logic [PS_W-1:0]     ps_cnt_reg, ps_cnt_next;
  logic [1:0]          inh_reg, inh_next;
  logic [WDT_W-1:0]    wdt_cnt_reg, wdt_cnt_next;
  logic                wdt_timeout_reg;
  logic                cfg_valid_reg, psa_reg;
  logic [PS_SEL_W-1:0] ps_reg;

  logic                sel_now, sel_prev, ext_tick, tick, cfg_chg;
  logic                tmr_inc, tmr_wrap, wdt_clear, wdt_tick, expire;
  logic [PS_SEL_W:0]   ps_plus1;
  logic [PS_W:0]       tmr_mask, wdt_mask, ps_cnt_ext;

  // Selecting the falling edge is done by inverting both sampled levels.
  assign sel_now  = sync2_reg ^ t0se;
  assign sel_prev = edge_reg ^ t0se;
  assign ext_tick = sel_now & ~sel_prev;
  assign tick     = t0cs ? ext_tick : ~sleep;

  // cfg_valid_reg keeps the first edge after reset from looking like a change.
  assign cfg_chg  = cfg_valid_reg & ((psa != psa_reg) | (ps != ps_reg));

  assign ps_plus1   = {1'b0, ps} + {{PS_SEL_W{1'b0}}, 1'b1};
  assign tmr_mask   = (SPAN_ONE << ps_plus1) - SPAN_ONE;
  assign wdt_mask   = (SPAN_ONE << ps) - SPAN_ONE;
  assign ps_cnt_ext = {1'b0, ps_cnt_reg};

  always_comb begin
    tmr_next     = tmr_reg;
    ps_cnt_next  = ps_cnt_reg;
    inh_next     = inh_reg;
    wdt_cnt_next = wdt_cnt_reg;
    tmr_inc      = 1'b0;
    tmr_wrap     = 1'b0;
    expire       = 1'b0;
    wdt_clear    = clrwdt | sleep;
    wdt_tick     = wdt_en & (&wdt_cnt_reg);

    if (inh_reg != 2'd0)
      inh_next = inh_reg - 2'd1;

    // A load wins over any tick in the same cycle and arms a 2-cycle hold-off.
    if (tmr_wr) begin
      tmr_next = tmr_wdata;
      inh_next = 2'd2;
      if (!psa)
        ps_cnt_next = '0;
    end else if (tick && inh_reg == 2'd0) begin
      if (psa) begin
        tmr_inc = 1'b1;
      end else if (!cfg_chg) begin
        tmr_inc     = ((ps_cnt_ext & tmr_mask) == tmr_mask);
        ps_cnt_next = ps_cnt_reg + PS_W'(1);
      end
    end

    if (tmr_inc) begin
      tmr_next = tmr_reg + TMR_W'(1);
      tmr_wrap = &tmr_reg;
    end
    ovf_next = tmr_wrap | (tmr_ovf_reg & ~ovf_clr);

    if (wdt_en)
      wdt_cnt_next = wdt_cnt_reg + WDT_W'(1);

    // Clearing the watchdog suppresses a same-cycle expiry.
    if (wdt_clear) begin
      wdt_cnt_next = '0;
      if (psa)
        ps_cnt_next = '0;
    end else if (wdt_tick) begin
      if (!psa) begin
        expire = 1'b1;
      end else if (!cfg_chg) begin
        if ((ps_cnt_ext & wdt_mask) == wdt_mask) begin
          expire      = 1'b1;
          ps_cnt_next = '0;
        end else begin
          ps_cnt_next = ps_cnt_reg + PS_W'(1);
        end
      end
    end

    if (expire)
      wdt_cnt_next = '0;
    if (cfg_chg)
      ps_cnt_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      edge_reg        <= 1'b0;
      tmr_reg         <= '0;
      tmr_ovf_reg     <= 1'b0;
      ps_cnt_reg      <= '0;
      inh_reg         <= 2'd0;
      wdt_cnt_reg     <= '0;
      wdt_timeout_reg <= 1'b0;
      cfg_valid_reg   <= 1'b0;
      psa_reg         <= 1'b0;
      ps_reg          <= '0;
    end else begin
      sync1_reg       <= t0cki;
      sync2_reg       <= sync1_reg;
      edge_reg        <= sync2_reg;
      tmr_reg         <= tmr_next;
      tmr_ovf_reg     <= ovf_next;
      ps_cnt_reg      <= ps_cnt_next;
      inh_reg         <= inh_next;
      wdt_cnt_reg     <= wdt_cnt_next;
      wdt_timeout_reg <= expire;
      cfg_valid_reg   <= 1'b1;
      psa_reg         <= psa;
      ps_reg          <= ps;
    end
  end

  assign tmr_q       = tmr_reg;
  assign tmr_ovf     = tmr_ovf_reg;
  assign wdt_timeout = wdt_timeout_reg;

endmodule
